bus_demux: RTL
==============

BUS_DEMUX -- requirements
Module: bus_demux

Interface
REQ-001 SHALL have parameter T0_BASE, default 32'h0000_0000, data-memory window base.
REQ-002 SHALL have parameter T0_MASK, default 32'hF000_0000, data-memory window decode mask.
REQ-003 SHALL have parameter T1_BASE, default 32'h1000_0000, MMIO window base.
REQ-004 SHALL have parameter T1_MASK, default 32'hF000_0000, MMIO window decode mask.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16, watchdog limit (used only under REQ-029).
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have these initiator ports: req_valid in 1; req_ready out 1; req_addr in 32; req_wdata in 32; req_we in 1 (1 = store); req_be in 4 (byte enables).
REQ-008 SHALL have these initiator response ports: rsp_valid out 1; rsp_rdata out 32; rsp_err out 1.
REQ-009 SHALL have these shared target request ports: t_addr out 32; t_wdata out 32; t_we out 1; t_be out 4.
REQ-010 SHALL have these per-target ports, for n in {0,1}: tn_req_valid out 1; tn_req_ready in 1; tn_rsp_valid in 1; tn_rdata in 32.

Function
REQ-011 SHALL decode req_addr combinationally: T1 if (addr & T1_MASK) == T1_BASE; else T0 if (addr & T0_MASK) == T0_BASE; else UNMAPPED. T1 takes priority.
REQ-012 SHALL drive t_addr, t_wdata, t_we and t_be directly from the req_* inputs, in every state.
REQ-013 SHALL have three FSM states: IDLE, WAIT, RESP.
REQ-014 In IDLE, SHALL drive tn_req_valid = req_valid && (decode == Tn); it SHALL be 0 in all other states.
REQ-015 In IDLE, SHALL drive req_ready = tn_req_ready of the decoded target, or 1 if UNMAPPED; req_ready SHALL be 0 in WAIT and RESP.
REQ-016 A request is accepted on a cycle with req_valid && req_ready.
REQ-017 On accept, SHALL register the target select and go IDLE->WAIT; if UNMAPPED, SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0.
REQ-018 In WAIT, on the selected target's rsp_valid, SHALL capture its rdata and go WAIT->RESP with rsp_err=0.
REQ-019 In WAIT, SHALL ignore rsp_valid from the non-selected target.
REQ-020 SHALL ignore a target rsp_valid arriving in the accept cycle; targets respond at least 1 cycle after accept.
REQ-021 In RESP, SHALL assert rsp_valid for exactly 1 cycle with the registered rsp_rdata/rsp_err, then go RESP->IDLE.
REQ-022 Latency: rsp_valid SHALL assert 1 cycle after target rsp_valid, or 1 cycle after accept for UNMAPPED.
REQ-023 Stores SHALL also complete through WAIT/RESP; rsp_rdata for a store is whatever the target returns.
REQ-024 At most one transaction SHALL be outstanding; back-to-back throughput is one transaction per 3 cycles minimum.

Reset
REQ-025 While rst_n=0, SHALL force state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clear the select register.
REQ-026 Reset asserted mid-transaction SHALL drop the in-flight transaction; no response is produced after reset release.
REQ-027 Immediately after reset, SHALL present req_ready per REQ-015.

Configuration
REQ-028 With BUS_DEMUX_TIMEOUT_EN undefined, WAIT SHALL persist until the selected target responds.
REQ-029 With BUS_DEMUX_TIMEOUT_EN defined, a counter SHALL clear on accept and increment each cycle in WAIT; when it reaches TIMEOUT_CYCLES with no response, SHALL go WAIT->RESP with rsp_err=1 and rsp_rdata=32'hDEAD_BEEF.
REQ-030 Under REQ-029, a response and the timeout in the same cycle SHALL resolve as a normal response.

Structure
REQ-031 SHALL place the state enum, target-select encoding and default window constants in shared package riscv_bus_pkg.
REQ-032 SHALL use one sub-module, bus_addr_decode, for the REQ-011 decode.

Verification
REQ-033 Load to 0x0000_0040 with t0_req_ready=1 and t0 responding 2 cycles later with 0x1234_5678 -> t0_req_valid for 1 cycle, rsp_valid 1 cycle after t0_rsp_valid, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-034 Store to 0x1000_0004 with be=4'b0011 -> t1_req_valid=1, t0_req_valid=0, t_be=4'b0011, single rsp_valid.
REQ-035 Access to 0x2000_0000 -> neither tn_req_valid asserted, rsp_valid next cycle with rsp_err=1 and rsp_rdata=0.
REQ-036 t0 request with t0_req_ready=0 for 3 cycles -> req_ready=0 and request held; accepted on the cycle t0_req_ready rises.
REQ-037 rst_n pulled low in WAIT, target response after release -> no rsp_valid; state IDLE.
REQ-038 With BUS_DEMUX_TIMEOUT_EN and TIMEOUT_CYCLES=16, t1 never responds -> rsp_valid with rsp_err=1 and rsp_rdata=0xDEAD_BEEF, 17 cycles after accept.

Source files
------------

// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg: shared types and default address windows for the bus demux.
// Contents: state_t (demux FSM states), sel_t (target select encoding),
// DEF_* default window constants and watchdog limit.
package riscv_bus_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   typedef enum logic [1:0] {SEL_T0 = 2'd0, SEL_T1 = 2'd1, SEL_NONE = 2'd2} sel_t;
   localparam logic [31:0] DEF_T0_BASE = 32'h0000_0000;
   localparam logic [31:0] DEF_T0_MASK = 32'hF000_0000;
   localparam logic [31:0] DEF_T1_BASE = 32'h1000_0000;
   localparam logic [31:0] DEF_T1_MASK = 32'hF000_0000;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: combinational address window decode for the bus demux.
// Ports: addr (in, 32) request address; sel (out, sel_t) decoded target.
// The MMIO window (T1) wins when both windows match.
module bus_addr_decode
   import riscv_bus_pkg::*;
#(
   parameter logic [31:0] T0_BASE = DEF_T0_BASE,
   parameter logic [31:0] T0_MASK = DEF_T0_MASK,
   parameter logic [31:0] T1_BASE = DEF_T1_BASE,
   parameter logic [31:0] T1_MASK = DEF_T1_MASK
) (
   input  logic [31:0] addr,
   output sel_t        sel
);
   assign sel = ((addr & T1_MASK) == T1_BASE) ? SEL_T1 :
                ((addr & T0_MASK) == T0_BASE) ? SEL_T0 : SEL_NONE;
endmodule

// File: rtl/bus_demux.sv
// bus_demux: single-outstanding 1-to-2 bus demultiplexer (data memory T0, MMIO T1).
// Ports: clk, rst_n (async active-low); initiator req_valid/req_ready/req_addr/
// req_wdata/req_we/req_be; response rsp_valid/rsp_rdata/rsp_err; shared target
// request t_addr/t_wdata/t_we/t_be; per target tN_req_valid/tN_req_ready/
// tN_rsp_valid/tN_rdata. Unmapped accesses answer with rsp_err=1, rdata=0.
// Macro BUS_DEMUX_TIMEOUT_EN: enables a WAIT watchdog of TIMEOUT_CYCLES that
// answers with rsp_err=1 and rdata=32'hDEAD_BEEF.
module bus_demux
   import riscv_bus_pkg::*;
#(
   parameter logic [31:0] T0_BASE        = DEF_T0_BASE,
   parameter logic [31:0] T0_MASK        = DEF_T0_MASK,
   parameter logic [31:0] T1_BASE        = DEF_T1_BASE,
   parameter logic [31:0] T1_MASK        = DEF_T1_MASK,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] t_addr,
   output logic [31:0] t_wdata,
   output logic        t_we,
   output logic [3:0]  t_be,
   output logic        t0_req_valid,
   input  logic        t0_req_ready,
   input  logic        t0_rsp_valid,
   input  logic [31:0] t0_rdata,
   output logic        t1_req_valid,
   input  logic        t1_req_ready,
   input  logic        t1_rsp_valid,
   input  logic [31:0] t1_rdata
);
   state_t state;
   sel_t   dec, sel_q;
   logic   idle, accept, tgt_rsp;
   logic [31:0] tgt_rdata;
   bus_addr_decode #(
      .T0_BASE(T0_BASE), .T0_MASK(T0_MASK), .T1_BASE(T1_BASE), .T1_MASK(T1_MASK)
   ) u_decode (
      .addr(req_addr),
      .sel (dec)
   );
   assign t_addr       = req_addr;
   assign t_wdata      = req_wdata;
   assign t_we         = req_we;
   assign t_be         = req_be;
   assign idle         = state == IDLE;
   assign t0_req_valid = idle && req_valid && dec == SEL_T0;
   assign t1_req_valid = idle && req_valid && dec == SEL_T1;
   // Unmapped requests are swallowed immediately and answered with an error.
   assign req_ready    = idle && (dec == SEL_T0 ? t0_req_ready :
                                  dec == SEL_T1 ? t1_req_ready : 1'b1);
   assign accept       = req_valid && req_ready;
   // Only the registered target's response is observed; the other is ignored.
   assign tgt_rsp      = sel_q == SEL_T1 ? t1_rsp_valid : t0_rsp_valid;
   assign tgt_rdata    = sel_q == SEL_T1 ? t1_rdata : t0_rdata;
`ifdef BUS_DEMUX_TIMEOUT_EN
   logic [31:0] cnt;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel_q     <= SEL_T0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef BUS_DEMUX_TIMEOUT_EN
         cnt       <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (accept) begin
               sel_q     <= dec;
               state     <= dec == SEL_NONE ? RESP : WAIT;
               rsp_valid <= dec == SEL_NONE;
               rsp_err   <= dec == SEL_NONE;
               rsp_rdata <= '0;
`ifdef BUS_DEMUX_TIMEOUT_EN
               cnt       <= '0;
`endif
            end
            WAIT: if (tgt_rsp) begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= tgt_rdata;
            end
`ifdef BUS_DEMUX_TIMEOUT_EN
            else if (cnt == TIMEOUT_CYCLES) begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
               rsp_rdata <= 32'hDEAD_BEEF;
            end else cnt <= cnt + 32'd1;
`endif
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
